// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: maximal tap masks, parameter limits and the single-shift equation.
package lfsr_pkg;

  localparam int unsigned LFSR_WIDTH_MIN = 3;
  localparam int unsigned LFSR_WIDTH_MAX = 32;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

  // Fibonacci shift-left with XOR feedback into bit 0; width trims the result so one
  // 32-bit function serves every legal WIDTH.
  function automatic logic [31:0] lfsr_shift(input logic [31:0] state,
                                             input logic [31:0] taps,
                                             input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return ((state << 1) | {31'd0, ^(state & taps)}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_prng_param_step.sv
// Combinational unroll of STEP single LFSR shifts.
module lfsr_step_unroll
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter int unsigned      STEP  = 1
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);

  logic [31:0] s;

  always_comb begin
    s = 32'(state_i);
    for (int unsigned i = 0; i < STEP; i++) begin
      s = lfsr_shift(s, 32'(TAPS), WIDTH);
    end
    state_o = s[WIDTH-1:0];
  end

endmodule

// File: rtl/lfsr_prng_param.sv
// Parametrised Fibonacci LFSR with STEP shifts per enable, protected seed load and period monitor.
module lfsr_prng_param
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int unsigned      STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] random_out,
  output logic             valid,
  output logic             period_done,
  output logic [WIDTH-1:0] period_cnt,
  output logic             seed_err
);

  if (SEED == '0) begin : g_seed_chk
    $error("lfsr_prng_param: SEED must be nonzero");
  end
  if (WIDTH < LFSR_WIDTH_MIN || WIDTH > LFSR_WIDTH_MAX) begin : g_width_chk
    $error("lfsr_prng_param: WIDTH out of range 3..32");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_step_chk
    $error("lfsr_prng_param: STEP out of range 1..WIDTH");
  end

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] adv;

  lfsr_step_unroll #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEP  (STEP)
  ) u_step (
    .state_i (state_q),
    .state_o (adv)
  );

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = err_q;
    if (load) begin
      // A zero seed would lock the register at zero, so fall back to SEED and flag it.
      if (seed_in == '0) begin
        state_d = SEED;
        start_d = SEED;
        err_d   = 1'b1;
      end else begin
        state_d = seed_in;
        start_d = seed_in;
      end
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (en) begin
      state_d = adv;
      valid_d = 1'b1;
      if (adv == start_q) begin
        done_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEED;
      start_q <= SEED;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign random_out  = state_q;
  assign valid       = valid_q;
  assign period_done = done_q;
  assign period_cnt  = cnt_q;
  assign seed_err    = err_q;

endmodule

// File: tb/tb_lfsr_prng_param.sv
// Directed plus randomized bench for lfsr_prng_param (STEP=1 and STEP=4 instances side by side).
module tb_lfsr_prng_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       load;
  logic [7:0] seed_in;

  logic [7:0] a_out, a_cnt, b_out, b_cnt;
  logic       a_valid, a_done, a_err, b_valid, b_done, b_err;

  always #5 clk = ~clk;

  lfsr_prng_param #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEP(1)) u_a (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .random_out(a_out), .valid(a_valid), .period_done(a_done),
    .period_cnt(a_cnt), .seed_err(a_err)
  );

  lfsr_prng_param #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEP(4)) u_b (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .random_out(b_out), .valid(b_valid), .period_done(b_done),
    .period_cnt(b_cnt), .seed_err(b_err)
  );

  int tests = 0;
  int fails = 0;

  // Reference model, one slot per instance.
  int m_st[2], m_start[2], m_cnt[2];
  bit m_valid[2], m_done[2], m_err[2];
  int m_step[2] = '{1, 4};

  // One shift: double modulo 256, add parity of the tapped bits (7,5,4,3).
  function automatic int next1(input int s);
    int p;
    p = $countones(8'(s) & 8'hB8) % 2;
    return (s * 2) % 256 + p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 1; m_start[k] = 1; m_cnt[k] = 0;
      m_valid[k] = 0; m_done[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_clock(input bit e, input bit l, input int sd);
    int n;
    for (int k = 0; k < 2; k++) begin
      if (l) begin
        if (sd == 0) begin
          m_st[k] = 1; m_start[k] = 1; m_err[k] = 1;
        end else begin
          m_st[k] = sd; m_start[k] = sd;
        end
        m_cnt[k] = 0; m_done[k] = 0; m_valid[k] = 1;
      end else if (e) begin
        n = m_st[k];
        for (int j = 0; j < m_step[k]; j++) n = next1(n);
        m_st[k] = n; m_valid[k] = 1;
        if (n == m_start[k]) begin
          m_done[k] = 1; m_cnt[k] = 0;
        end else begin
          m_done[k] = 0; m_cnt[k] = (m_cnt[k] + 1) % 256;
        end
      end else begin
        m_done[k] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_out",   32'(a_out),   32'(m_st[0]));
    chk("a_valid", 32'(a_valid), 32'(m_valid[0]));
    chk("a_done",  32'(a_done),  32'(m_done[0]));
    chk("a_cnt",   32'(a_cnt),   32'(m_cnt[0]));
    chk("a_err",   32'(a_err),   32'(m_err[0]));
    chk("b_out",   32'(b_out),   32'(m_st[1]));
    chk("b_valid", 32'(b_valid), 32'(m_valid[1]));
    chk("b_done",  32'(b_done),  32'(m_done[1]));
    chk("b_cnt",   32'(b_cnt),   32'(m_cnt[1]));
    chk("b_err",   32'(b_err),   32'(m_err[1]));
  endtask

  // Inputs set between edges, sampled 1 time unit after the edge.
  task automatic step(input bit e, input bit l, input logic [7:0] sd);
    en = e; load = l; seed_in = sd;
    @(posedge clk);
    model_clock(e, l, int'(sd));
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs checked before any edge.
  task automatic do_reset();
    #1 reset = 1'b0;
    model_reset();
    #1 check_all();
    #1 reset = 1'b1;
  endtask

  int pulses, pulse_at;
  bit r_en, r_load;
  logic [7:0] r_seed;

  initial begin
    reset = 1'b0; en = 1'b0; load = 1'b0; seed_in = 8'h00;
    model_reset();
    #12;
    check_all();
    chk("rst_out", 32'(a_out), 32'h01);
    reset = 1'b1;

    // Four advances from reset.
    for (int i = 0; i < 4; i++) step(1, 0, 8'h00);
    chk("seq4_out", 32'(a_out), 32'h11);
    chk("seq4_cnt", 32'(a_cnt), 32'd4);
    chk("seq4_valid", 32'(a_valid), 32'd1);

    // Full period with defaults.
    do_reset();
    pulses = 0; pulse_at = 0;
    for (int i = 1; i <= 255; i++) begin
      step(1, 0, 8'h00);
      if (a_done) begin
        pulses++;
        pulse_at = i;
      end
    end
    chk("period_pulses", 32'(pulses), 32'd1);
    chk("period_at", 32'(pulse_at), 32'd255);
    chk("period_out", 32'(a_out), 32'h01);
    chk("period_cnt", 32'(a_cnt), 32'd0);
    step(0, 0, 8'h00);
    chk("period_done_drop", 32'(a_done), 32'd0);

    // STEP=4 single advance.
    do_reset();
    step(1, 0, 8'h00);
    chk("step4_out", 32'(b_out), 32'h11);
    chk("step4_cnt", 32'(b_cnt), 32'd1);

    // Zero-seed protection and sticky error.
    step(0, 1, 8'h00);
    chk("zload_out", 32'(a_out), 32'h01);
    chk("zload_err", 32'(a_err), 32'd1);
    step(0, 1, 8'h5A);
    chk("nzload_out", 32'(a_out), 32'h5A);
    chk("nzload_err", 32'(a_err), 32'd1);
    do_reset();
    chk("err_cleared", 32'(a_err), 32'd0);

    // load wins over en.
    step(1, 1, 8'h80);
    chk("ldén_out", 32'(a_out), 32'h80);
    chk("lden_cnt", 32'(a_cnt), 32'd0);
    step(1, 0, 8'h00);
    chk("lden_next", 32'(a_out), 32'h01);

    // Mid-run asynchronous reset with en held high.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 8'h00);
    do_reset();
    chk("midrst_out", 32'(a_out), 32'h01);
    chk("midrst_valid", 32'(a_valid), 32'd0);
    step(1, 0, 8'h00);
    chk("restart_out", 32'(a_out), 32'h02);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r_en   = ($urandom_range(99) < 70);
      r_load = ($urandom_range(99) < 10);
      r_seed = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      step(r_en, r_load, r_seed);
      if ($urandom_range(99) < 2) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
